// File: rtl/beat_tick_gen.sv
// rtl/beat_tick_gen.sv - level-selected beat tick / half tick generator (optional beat counter: BEAT_TICK_BEAT_CNT_EN)
//
// Divides clk by BASE_DIV >> lvl_act and emits one-cycle tick and tick_half
// strobes. Level requests are clamped and only take effect on a period wrap
// or a phase clear, so a running period is never shortened or stretched.
// Define BEAT_TICK_BEAT_CNT_EN to add the beat output and its counter.
module beat_tick_gen #(
  parameter int CNT_W    = 19,
  parameter int BASE_DIV = 500000,
  parameter int NUM_LVL  = 3,
  parameter int LVL_W    = 2,
  parameter int BEAT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [LVL_W-1:0] lvl,
  output logic             tick,
  output logic             tick_half,
  output logic [LVL_W-1:0] lvl_act
`ifdef BEAT_TICK_BEAT_CNT_EN
  ,
  output logic [BEAT_W-1:0] beat
`endif
);

  localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(NUM_LVL - 1);
  localparam logic [31:0]      NUM_LVL_U = 32'(NUM_LVL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Period length in clk cycles for a given level.
  function automatic logic [CNT_W-1:0] period_of(input logic [LVL_W-1:0] l);
    logic [31:0] base;
    base      = 32'(BASE_DIV);
    period_of = CNT_W'(base >> l);
  endfunction

  // State registers and their next-state values.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] lvl_act_q, lvl_act_d;
  logic             tick_q, tick_d;
  logic             half_q, half_d;
`ifdef BEAT_TICK_BEAT_CNT_EN
  logic [BEAT_W-1:0] beat_q, beat_d;
`else
  logic unused_cfg;
  assign unused_cfg = (BEAT_W > 0);
`endif

  // Decode signals derived from the level actually in effect.
  logic [LVL_W-1:0] lvl_sel;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] half_pre;
  logic             at_wrap;
  logic             at_half;

  // Clamp the requested level into the supported range before it can be loaded.
  always_comb begin
    lvl_sel = lvl;
    if (32'(lvl) >= NUM_LVL_U) begin
      lvl_sel = LVL_MAX;
    end
  end

  // Period compares always use the registered level, never the raw request.
  always_comb begin
    period   = period_of(lvl_act_q);
    last_cnt = period - CNT_ONE;
    half_pre = (period >> 1) - CNT_ONE;
    // >= guards against a count left above the end value; the level only
    // changes with the count at zero, so in practice this is an equality.
    at_wrap  = (cnt_q >= last_cnt);
    at_half  = (cnt_q == half_pre);
  end

  // Next-state logic: clear beats run, run beats pause.
  always_comb begin
    cnt_d     = cnt_q;
    lvl_act_d = lvl_act_q;
    tick_d    = 1'b0;
    half_d    = 1'b0;
`ifdef BEAT_TICK_BEAT_CNT_EN
    beat_d    = beat_q;
`endif
    if (clr) begin
      // Phase clear: restart the period under the requested level, no strobe.
      cnt_d     = '0;
      lvl_act_d = lvl_sel;
`ifdef BEAT_TICK_BEAT_CNT_EN
      beat_d    = '0;
`endif
    end else if (run) begin
      half_d = at_half;
      if (at_wrap) begin
        // Period boundary: strobe and pick up any pending level request.
        cnt_d     = '0;
        tick_d    = 1'b1;
        lvl_act_d = lvl_sel;
`ifdef BEAT_TICK_BEAT_CNT_EN
        beat_d    = beat_q + BEAT_W'(1);
`endif
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State update with asynchronous reset to level 0, count 0, strobes low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      lvl_act_q <= '0;
      tick_q    <= 1'b0;
      half_q    <= 1'b0;
`ifdef BEAT_TICK_BEAT_CNT_EN
      beat_q    <= '0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      lvl_act_q <= lvl_act_d;
      tick_q    <= tick_d;
      half_q    <= half_d;
`ifdef BEAT_TICK_BEAT_CNT_EN
      beat_q    <= beat_d;
`endif
    end
  end

  assign tick      = tick_q;
  assign tick_half = half_q;
  assign lvl_act   = lvl_act_q;
`ifdef BEAT_TICK_BEAT_CNT_EN
  assign beat      = beat_q;
`endif

endmodule

// File: tb/tb_beat_tick_gen.sv
// tb/tb_beat_tick_gen.sv - self-checking bench for beat_tick_gen
module tb_beat_tick_gen;

  localparam int CNT_W    = 5;
  localparam int BASE_DIV = 16;
  localparam int NUM_LVL  = 3;
  localparam int LVL_W    = 2;
  localparam int BEAT_W   = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             clr = 1'b0;
  logic [LVL_W-1:0] lvl = '0;
  logic             tick;
  logic             tick_half;
  logic [LVL_W-1:0] lvl_act;
`ifdef BEAT_TICK_BEAT_CNT_EN
  logic [BEAT_W-1:0] beat;
`endif

  beat_tick_gen #(
    .CNT_W(CNT_W), .BASE_DIV(BASE_DIV), .NUM_LVL(NUM_LVL), .LVL_W(LVL_W), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr(clr), .lvl(lvl),
    .tick(tick), .tick_half(tick_half), .lvl_act(lvl_act)
`ifdef BEAT_TICK_BEAT_CNT_EN
    , .beat(beat)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int tick_edges[$];
  int half_edges[$];
  int beat_seq[$];

  // Reference model: cycles remaining in the current period.
  int m_rem, m_per, m_act, m_beat;
  bit m_tick, m_half;

  function automatic int clampl(int l);
    return (l >= NUM_LVL) ? NUM_LVL - 1 : l;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic chk_tick(string name, int idx, int exp);
    if (idx < tick_edges.size()) chk(name, tick_edges[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s: tick #%0d missing expected at edge %0d", name, idx, exp);
    end
  endtask

  task automatic chk_half(string name, int idx, int exp);
    if (idx < half_edges.size()) chk(name, half_edges[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s: tick_half #%0d missing expected at edge %0d", name, idx, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_per = BASE_DIV; m_rem = BASE_DIV;
    m_tick = 0; m_half = 0; m_beat = 0;
  endtask

  task automatic model_edge(bit r, bit c, int l);
    if (c) begin
      m_act = clampl(l); m_per = BASE_DIV >> m_act; m_rem = m_per;
      m_tick = 0; m_half = 0; m_beat = 0;
    end else if (r) begin
      m_rem--;
      m_half = ((m_per - m_rem) == m_per / 2);
      m_tick = (m_rem == 0);
      if (m_tick) begin
        m_act  = clampl(l); m_per = BASE_DIV >> m_act; m_rem = m_per;
        m_beat = (m_beat + 1) % (1 << BEAT_W);
      end
    end else begin
      m_tick = 0; m_half = 0;
    end
  endtask

  task automatic compare_outputs();
    chk("tick", int'(tick), int'(m_tick));
    chk("tick_half", int'(tick_half), int'(m_half));
    chk("lvl_act", int'(lvl_act), m_act);
`ifdef BEAT_TICK_BEAT_CNT_EN
    chk("beat", int'(beat), m_beat);
    if (tick) beat_seq.push_back(int'(beat));
`endif
    if (tick) tick_edges.push_back(edge_n);
    if (tick_half) half_edges.push_back(edge_n);
  endtask

  // Entered and left at a falling edge: drive, clock, model, compare.
  task automatic step(bit r, bit c, int l);
    run = r; clr = c; lvl = LVL_W'(l);
    @(posedge clk);
    model_edge(r, c, l);
    edge_n++;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; clr = 1'b0; lvl = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tick", int'(tick), 0);
    chk("reset_half", int'(tick_half), 0);
    chk("reset_lvl_act", int'(lvl_act), 0);
`ifdef BEAT_TICK_BEAT_CNT_EN
    chk("reset_beat", int'(beat), 0);
`endif
    rst_n = 1'b1;
    model_reset();
    edge_n = 0;
    tick_edges.delete(); half_edges.delete(); beat_seq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet;
    int l;
    @(negedge clk);

    // Free run at level 0.
    do_reset();
    repeat (50) step(1, 0, 0);
    chk_tick("free_tick0", 0, 16);
    chk_tick("free_tick1", 1, 32);
    chk_tick("free_tick2", 2, 48);
    chk_half("free_half0", 0, 8);
    chk_half("free_half1", 1, 24);
    chk_half("free_half2", 2, 40);
    chk("free_lvl_act", int'(lvl_act), 0);

    // Mid-period level change takes effect at the next wrap.
    do_reset();
    repeat (5) step(1, 0, 0);
    repeat (25) step(1, 0, 2);
    chk_tick("chg_tick0", 0, 16);
    chk_tick("chg_tick1", 1, 20);
    chk_tick("chg_tick2", 2, 24);
    chk_tick("chg_tick3", 3, 28);
    chk("chg_lvl_act", int'(lvl_act), 2);

    // Pause of 10 cycles from cycle 12.
    do_reset();
    repeat (12) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    repeat (20) step(1, 0, 0);
    chk_tick("pause_tick0", 0, 26);
    chk_half("pause_half0", 0, 8);
    quiet = 0;
    foreach (tick_edges[i]) if (tick_edges[i] >= 13 && tick_edges[i] <= 22) quiet++;
    foreach (half_edges[i]) if (half_edges[i] >= 13 && half_edges[i] <= 22) quiet++;
    chk("pause_quiet", quiet, 0);

    // Clear together with run at cnt=15.
    do_reset();
    repeat (15) step(1, 0, 0);
    step(1, 1, 0);
    chk("clr_no_tick", int'(tick), 0);
    repeat (20) step(1, 0, 0);
    chk_tick("clr_next_tick", 0, 32);

    // Level clamp, then async reset while a tick is high.
    do_reset();
    step(1, 1, 3);
    chk("clamp_lvl_act", int'(lvl_act), 2);
    repeat (10) step(1, 0, 3);
    chk_tick("clamp_tick0", 0, 5);
    chk_tick("clamp_tick1", 1, 9);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 3);
      if (tick) break;
    end
    chk("pre_rst_tick", int'(tick), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tick", int'(tick), 0);
    chk("async_rst_half", int'(tick_half), 0);
    chk("async_rst_lvl_act", int'(lvl_act), 0);
`ifdef BEAT_TICK_BEAT_CNT_EN
    chk("async_rst_beat", int'(beat), 0);
`endif
    @(negedge clk);

    // Beat counter over nine ticks.
    do_reset();
    repeat (9 * 16 + 2) step(1, 0, 0);
    chk("nine_ticks", tick_edges.size(), 9);
`ifdef BEAT_TICK_BEAT_CNT_EN
    begin
      int exp_beats[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
      for (int i = 0; i < 9; i++) begin
        if (i < beat_seq.size()) chk("beat_seq", beat_seq[i], exp_beats[i]);
        else begin
          checks++; errors++;
          $display("FAIL beat_seq: entry %0d missing expected %0d", i, exp_beats[i]);
        end
      end
    end
`endif

    // Randomized run/pause/clear/level traffic.
    do_reset();
    l = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) l = int'($urandom_range(0, 3));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, l);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/beat_tick_gen.md
# beat_tick_gen

Parametrised beat-tick generator for the game timing path, the next generation of the fixed three-speed 32 pps tick source. It divides `clk` by a level-selected period and emits one-cycle `tick` strobes plus a mid-period `tick_half` strobe. Level changes are applied glitch-free at period boundaries. The block supports pause/resume without losing phase and a synchronous phase clear. Note arrows, scroll and hit windows consume these strobes as clock enables.

## Interface
Parameters:
- `CNT_W`, 19: period counter width.
- `BASE_DIV`, 500000: period in `clk` cycles at level 0; must fit in `CNT_W` bits.
- `NUM_LVL`, 3: number of speed levels; level n period = `BASE_DIV >> n`. `BASE_DIV >> (NUM_LVL-1)` must be >= 2.
- `LVL_W`, 2: width of the level select.
- `BEAT_W`, 8: beat counter width (only with `BEAT_TICK_BEAT_CNT_EN`).

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: asynchronous active-low reset.
- `run`, in, 1: 1 = count, 0 = pause (hold count, no strobes).
- `clr`, in, 1: synchronous phase clear.
- `lvl`, in, `LVL_W`: requested speed level.
- `tick`, out, 1: one-cycle strobe, once per period.
- `tick_half`, out, 1: one-cycle strobe at mid-period.
- `lvl_act`, out, `LVL_W`: level currently in effect.
- `beat`, out, `BEAT_W`: beats elapsed (only with macro).

## Operation
- **Active period:** P = `BASE_DIV >> lvl_act`. Counter `cnt` runs 0..P-1.
- **Clamping:** `lvl` >= `NUM_LVL` is clamped to `NUM_LVL-1` before loading.
- **run=1, clr=0:** `cnt` increments each cycle and wraps P-1 -> 0. The wrap edge registers `tick`=1 for one cycle. The edge where `cnt` goes (P/2)-1 -> P/2 registers `tick_half`=1 (P/2 is an integer divide).
- **Level change:** `lvl_act` loads the clamped `lvl` only on a wrap edge, or on any edge with `clr`=1. A mid-period `lvl` change therefore never shortens or stretches the current period.
- **run=0:** `cnt`, `lvl_act` and `beat` hold. `tick` and `tick_half` are 0. Resuming continues from the held count, so the remaining period is preserved.
- **clr=1:** has priority over `run`. On that edge: `cnt`<=0, `lvl_act`<=clamped `lvl`, `beat`<=0, and `tick`/`tick_half`<=0. No strobe is emitted for a clear, even when `cnt` was P-1.
- **Counter width:** arithmetic is unsigned `CNT_W`. Period compares use the registered `lvl_act`, never the raw `lvl`.

## Timing
- **Reset values (rst_n=0):** `cnt`=0, `lvl_act`=0, `tick`=0, `tick_half`=0, `beat`=0. Level 0 is active after reset until the first wrap or `clr`.
- **Registered outputs:** all outputs are registered, with no combinational path from inputs to outputs.
- **First tick:** with run=1 from reset release, the first `tick` is high in the cycle after the P-th rising edge. Subsequent ticks are exactly P cycles apart while running.
- **Latency:** `tick_half` is high P/2 cycles after each period start.
- **Level change:** a change requested k cycles before a wrap takes effect for the period starting at that wrap. `lvl_act` updates on the same edge that raises `tick`.
- **Pause:** a pause of N cycles delays all following strobes by exactly N cycles.
- **Reset mid-period:** reset mid-period returns every output to its reset value. Counting restarts from 0 on the first edge after `rst_n` rises.

## Configuration
- **Macro `BEAT_TICK_BEAT_CNT_EN`:**
  - **Defined:** `beat` port and counter exist. `beat` increments on every `tick` edge, wraps 2^`BEAT_W`-1 -> 0, clears on `clr`, and holds on `run`=0.
  - **Undefined:** the `beat` port and its counter are absent. All other behaviour is identical.

## Test plan
Bench configuration: `BASE_DIV`=16, `NUM_LVL`=3 (periods 16/8/4), `LVL_W`=2, `BEAT_W`=3.
- **Free run:** reset release with run=1, lvl=0 -> `tick` at cycles 16, 32, 48; `tick_half` at cycles 8, 24, 40; `lvl_act`=0.
- **Mid-period level change:** lvl=2 set at cycle 5 -> next tick still at cycle 16 with `lvl_act`=2 there, then ticks at 20, 24, 28.
- **Level clamp:** lvl=3 then clr -> `lvl_act`=2, period 4.
- **Pause:** run=0 for 10 cycles starting at cycle 12 -> tick moves from 16 to 26, and no strobes occur during the pause.
- **Clear priority:** clr together with run=1 at cnt=15 -> no tick, cnt=0, and the next tick comes 16 cycles later.
- **Beat counter (macro on):** 9 ticks -> `beat` sequence 1..7, 0, 1. An async `rst_n` pulse mid-period -> all outputs 0 immediately.
